// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-NCH stream demultiplexer with valid/ready.
// Each output channel owns a one-entry register, so a stalled consumer only
// blocks the producer when the current word targets that consumer.
// Optional per-channel transfer counters: define DMUX_STREAM_CNT_EN.

module dmux_stream_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,        // word for this lane accepted this cycle
    input  logic [WIDTH-1:0] din,
    input  logic             dout_ready,
    output logic             lane_rdy,   // lane can take a word this cycle
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
`ifdef DMUX_STREAM_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_st_e;

    lane_st_e st, st_nxt;
    logic     drain;

    assign dout_valid = (st == FULL);
    assign drain      = dout_valid && dout_ready;
    // A full lane still accepts when its consumer drains in the same cycle.
    assign lane_rdy   = (st == EMPTY) || dout_ready;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= EMPTY;
        else        st <= st_nxt;
    end

    // Next occupancy: accept wins over drain (refill keeps the lane full).
    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY: if (acc) st_nxt = FULL;
            FULL:  if (!acc && dout_ready) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    // Lane data: load on accept, clear on a drain with no refill so an idle lane reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout <= '0;
        else if (acc)   dout <= din;
        else if (drain) dout <= '0;
    end

`ifdef DMUX_STREAM_CNT_EN
    // Transfer counter; clear has priority over a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (drain)   cnt <= cnt + 16'd1;
    end
`endif

endmodule

module dmux_stream #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]       dout_valid,
    input  logic [NCH-1:0]       dout_ready,
    output logic                 err_sel
`ifdef DMUX_STREAM_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [NCH*16-1:0]    cnt
`endif
);

    localparam int          NSEL  = 1 << SEL_W;
    localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NCH);

    logic [NCH-1:0]  lane_rdy;
    logic [NCH-1:0]  lane_acc;
    logic [NSEL-1:0] rdy_pad;
    logic            in_range;
    logic            acc;

    assign in_range = ({1'b0, sel} < NCH_L);

    // Out-of-range selects see a padded ready of 1: those words are always
    // accepted and dropped.
    always_comb begin
        rdy_pad          = '1;
        rdy_pad[NCH-1:0] = lane_rdy;
    end

    assign din_ready = rdy_pad[sel];
    assign acc       = din_valid && din_ready;

    // Error pulse for the cycle after an accepted out-of-range word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sel <= 1'b0;
        else        err_sel <= acc && !in_range;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign lane_acc[k] = acc && (sel == SEL_W'(k));

        dmux_stream_lane #(.WIDTH(WIDTH)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .acc        (lane_acc[k]),
            .din        (din),
            .dout_ready (dout_ready[k]),
            .lane_rdy   (lane_rdy[k]),
            .dout       (dout[k*WIDTH +: WIDTH]),
            .dout_valid (dout_valid[k])
`ifdef DMUX_STREAM_CNT_EN
            ,
            .cnt_clr    (cnt_clr),
            .cnt        (cnt[k*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Randomized + directed bench for dmux_stream against a queue-based model.
// Counter checks are built only when DMUX_STREAM_CNT_EN is defined.

module tb_dmux_stream;

    localparam int W = 32;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic [1:0]    sel;
    logic          din_valid;
    logic          din_ready;
    logic [N*W-1:0] dout;
    logic [N-1:0]  dout_valid;
    logic [N-1:0]  dout_ready;
    logic          err_sel;
    logic          cnt_clr;
    logic [N*16-1:0] cnt;

    // second instance with a non-power-of-two channel count
    logic [W-1:0]  din3;
    logic [1:0]    sel3;
    logic          din3_valid;
    logic          din3_ready;
    logic [3*W-1:0] dout3;
    logic [2:0]    dout3_valid;
    logic [2:0]    dout3_ready;
    logic          err3;
    logic [3*16-1:0] cnt3;

    int n_chk  = 0;
    int n_fail = 0;
    int xfers  = 0;

    // reference model: per-channel queue of held words (capacity one)
    logic [W-1:0] q [N][$];
    logic         exp_err;
    logic [15:0]  cnt_m [N];

    always #5 clk = ~clk;

    dmux_stream #(.WIDTH(W), .NCH(N), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .err_sel(err_sel)
`ifdef DMUX_STREAM_CNT_EN
        , .cnt_clr(cnt_clr), .cnt(cnt)
`endif
    );

    dmux_stream #(.WIDTH(W), .NCH(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .din_valid(din3_valid),
        .din_ready(din3_ready), .dout(dout3), .dout_valid(dout3_valid),
        .dout_ready(dout3_ready), .err_sel(err3)
`ifdef DMUX_STREAM_CNT_EN
        , .cnt_clr(cnt_clr), .cnt(cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            cnt_m[k] = '0;
        end
        exp_err = 1'b0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("valid%0d", k), 64'(dout_valid[k]), 64'(q[k].size() != 0));
            chk($sformatf("lane%0d", k), 64'(dout[k*W +: W]),
                64'((q[k].size() != 0) ? q[k][0] : '0));
`ifdef DMUX_STREAM_CNT_EN
            chk($sformatf("cnt%0d", k), 64'(cnt[k*16 +: 16]), 64'(cnt_m[k]));
`endif
        end
        chk("err_sel", 64'(err_sel), 64'(exp_err));
    endtask

    // One clock: inputs are already driven. Checks ready before the edge,
    // advances the model at the edge, checks outputs just after.
    task automatic step();
        logic exp_rdy;
        logic acc;
        #1;
        exp_rdy = (q[sel].size() == 0) || dout_ready[sel];
        chk("din_ready", 64'(din_ready), 64'(exp_rdy));
        acc = din_valid && exp_rdy;
        xfers += $countones(dout_valid & dout_ready);
        @(posedge clk);
        for (int k = 0; k < N; k++)
            if (q[k].size() != 0 && dout_ready[k]) begin
                void'(q[k].pop_front());
                cnt_m[k] = cnt_m[k] + 16'd1;
            end
        if (cnt_clr)
            for (int k = 0; k < N; k++) cnt_m[k] = '0;
        exp_err = 1'b0;
        if (acc) q[sel].push_back(din);
        if (q[sel].size() > 1) chk("model_overflow", 64'(q[sel].size()), 64'd1);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        din_valid = 1'b1; sel = s; din = d;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; sel = '0; din_valid = 1'b0; dout_ready = '0; cnt_clr = 1'b0;
        din3 = '0; sel3 = '0; din3_valid = 1'b0; dout3_ready = '1;
        model_clear();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs();
        chk("rst_valid3", 64'(dout3_valid), 64'd0);

        // basic routing: four words, four lanes, all consumers ready
        dout_ready = '1;
        xfers = 0;
        send(2'd0, 32'h11);
        chk("route_lane0", 64'(dout[31:0]), 64'h11);
        chk("route_others0", 64'(dout[N*W-1:W] == '0), 64'd1);
        send(2'd1, 32'h22);
        send(2'd2, 32'h33);
        send(2'd3, 32'h44);
        step();
        chk("route_xfers", 64'(xfers), 64'd4);

        // backpressure on channel 1
        dout_ready = 4'b1101;
        send(2'd1, 32'hA5A5A5A5);
        din_valid = 1'b1; sel = 2'd1; din = 32'h5A5A5A5A;
        #1 chk("bp_blocked", 64'(din_ready), 64'd0);
        step();
        chk("bp_hold", 64'(dout[W +: W]), 64'hA5A5A5A5);
        step();
        chk("bp_hold2", 64'(dout[W +: W]), 64'hA5A5A5A5);
        dout_ready = 4'b1111;
        #1 chk("bp_refill_rdy", 64'(din_ready), 64'd1);
        step();
        chk("bp_second", 64'(dout[W +: W]), 64'h5A5A5A5A);
        din_valid = 1'b0;
        step();

        // independence: channel 0 stalled and full, channel 3 still accepts
        dout_ready = 4'b0110;
        send(2'd0, 32'h12);
        din_valid = 1'b1; sel = 2'd3; din = 32'h77;
        #1 chk("indep_rdy", 64'(din_ready), 64'd1);
        step();
        din_valid = 1'b0;
        chk("indep_valid", 64'(dout_valid), 64'b1001);
        dout_ready = '1;
        step();

        // invalid select on the 3-channel instance
        din3_valid = 1'b1; sel3 = 2'd3; din3 = 32'hFF;
        #1 chk("inv_rdy", 64'(din3_ready), 64'd1);
        @(posedge clk); #1;
        din3_valid = 1'b0;
        chk("inv_err", 64'(err3), 64'd1);
        chk("inv_valid", 64'(dout3_valid), 64'd0);
        @(posedge clk); #1;
        chk("inv_err_once", 64'(err3), 64'd0);
        chk("inv_valid2", 64'(dout3_valid), 64'd0);
        din3_valid = 1'b1; sel3 = 2'd2; din3 = 32'hC3;
        @(posedge clk); #1;
        din3_valid = 1'b0;
        chk("n3_valid", 64'(dout3_valid), 64'b100);
        chk("n3_lane2", 64'(dout3[2*W +: W]), 64'hC3);
        chk("n3_err", 64'(err3), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            din_valid  = ($urandom_range(0, 3) != 0);
            sel        = 2'($urandom_range(0, 3));
            din        = $urandom;
            dout_ready = 4'($urandom);
            step();
        end

`ifdef DMUX_STREAM_CNT_EN
        // counters: clear, five transfers on channel 2
        din_valid = 1'b0; dout_ready = '1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(2'd2, 32'(100 + i));
        step();
        chk("cnt_five", 64'(cnt[2*16 +: 16]), 64'd5);
        chk("cnt_others", 64'({cnt[63:48], cnt[31:0]}), 64'd0);
        send(2'd2, 32'h600);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_xfer", 64'(cnt[2*16 +: 16]), 64'd0);
        // 65536 back-to-back transfers wrap the counter to zero
        din_valid = 1'b1; sel = 2'd2;
        for (int i = 0; i < 65536; i++) begin
            din = 32'(i);
            step();
        end
        din_valid = 1'b0;
        step();
        chk("cnt_wrap", 64'(cnt[2*16 +: 16]), 64'd0);
`endif

        // asynchronous reset with channel 2 holding a word
        dout_ready = 4'b1011;
        send(2'd2, 32'hDEADBEEF);
        chk("pre_rst_lane2", 64'(dout[2*W +: W]), 64'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_lane2", 64'(dout[2*W +: W]), 64'd0);
        chk("rst_lanes", 64'(dout == '0), 64'd1);
        chk("rst_err", 64'(err_sel), 64'd0);
        model_clear();
        @(posedge clk); #2;
        rst_n = 1'b1;
        din_valid = 1'b1; sel = 2'd2; din = 32'h1;
        #1 chk("rst_ready", 64'(din_ready), 64'd1);
        dout_ready = '1;
        step();
        din_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised registered 1-to-NCH demultiplexer with valid/ready handshakes.
- Routes each accepted input word to the output channel given by sel. Each channel owns a one-entry output register, so one stalled channel does not block the others unless the input targets it.
- Sits between a single producer and up to NCH independent consumers.
- Unselected or empty lanes drive zero.

Parameters:
- WIDTH, 32, data width per word.
- NCH, 4, number of output channels (2..16; need not be a power of 2).
- SEL_W, 2, sel width; must satisfy 2**SEL_W >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input data word.
- sel  input  SEL_W  destination channel for din.
- din_valid  input  1  producer offers din/sel.
- din_ready  output  1  block can accept this cycle.
- dout  output  NCH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
- dout_valid  output  NCH  per-channel data valid.
- dout_ready  input  NCH  per-channel consumer ready.
- err_sel  output  1  one-cycle pulse when a word with sel >= NCH is accepted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). The reset value of every output register is zero.
  - On rst_n low: all dout_valid = 0, all dout lanes = 0, err_sel = 0, din_ready reflects empty channels.
  - Reset mid-transfer discards held words without delivering them.
- Per-channel state: one-entry register, EMPTY or FULL.
  - EMPTY -> FULL when a word for this channel is accepted.
  - FULL -> EMPTY when dout_ready[k] is high with no new word for k.
  - FULL -> FULL with new data when drain and accept for k coincide in the same cycle.
- din_ready (combinational):
  - If sel < NCH: high when channel sel is EMPTY, or when it is FULL and dout_ready[sel] = 1 (pass-through refill).
  - If sel >= NCH: always high.
- Accept occurs on din_valid && din_ready at the rising edge.
  - Data appears on the lane on the next cycle: latency 1 cycle, with dout_valid[sel] = 1.
- Output handshake: channel k transfers on dout_valid[k] && dout_ready[k].
  - Data is held stable while valid is high and ready is low.
- Lane zeroing: a lane whose dout_valid is 0 drives all-zero data. This is a registered clear, applied on the drain cycle.
- Invalid sel (sel >= NCH):
  - The word is accepted and dropped.
  - err_sel = 1 for exactly the following cycle.
  - No channel state changes.
- Throughput:
  - Back-to-back words to different channels: accepted every cycle.
  - Back-to-back words to the same channel: every cycle only if that consumer holds ready high.
- Independence: channels drain independently. Simultaneous drains on several channels plus one accept in the same cycle are all legal.
- Inputs: din and sel are ignored when din_valid = 0.

Optional Feature:
- Macro: DMUX_STREAM_CNT_EN.
- When defined:
  - Adds output port cnt of width NCH*16.
  - Holds one 16-bit counter per channel that increments on each output transfer (dout_valid[k] && dout_ready[k]).
  - Counters wrap at 0xFFFF -> 0x0000 and reset to 0 on rst_n low.
  - Adds input cnt_clr (1 bit), which synchronously zeroes all counters. If cnt_clr coincides with a transfer, the counter becomes 0.
- When undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: rst_n low mid-operation with channel 2 FULL holding 0xDEADBEEF.
  - Required: dout_valid = 4'b0000 and all lanes 0 immediately (asynchronous). After release, din_ready = 1.
- Basic routing:
  - Stimulus: sel = 0,1,2,3 with din = 0x11,0x22,0x33,0x44 on consecutive cycles, all dout_ready = 1.
  - Required: each word appears on its lane one cycle after acceptance. Other lanes stay 0. Four transfers complete in 5 cycles.
- Backpressure:
  - Stimulus: dout_ready[1] = 0; send 0xA5A5A5A5 then 0x5A5A5A5A, both to sel = 1.
  - Required: the second word sees din_ready = 0, and the first word is held stable. Raise dout_ready[1]: the first word is consumed, the second is accepted the same cycle and appears the next cycle.
- Independence:
  - Stimulus: channel 0 stalled and FULL; send 0x77 to sel = 3.
  - Required: accepted immediately; dout_valid = 4'b1001.
- Invalid select:
  - Stimulus: NCH = 3, SEL_W = 2, sel = 3, din = 0xFF, din_valid = 1.
  - Required: din_ready = 1, err_sel pulses 1 cycle, dout_valid stays 3'b000.
- Counters (with DMUX_STREAM_CNT_EN):
  - Stimulus: 5 transfers on channel 2.
  - Required: cnt lane 2 = 5, others 0. Assert cnt_clr concurrent with a 6th transfer: cnt lane 2 = 0. Preload/run past 0xFFFF: counter wraps to 0.
